// File: rtl/spike_aer_pkg.sv
// Shared types and defaults for the spike AER encoder.
package spike_aer_pkg;

    localparam int AER_N_NEURONS = 16;
    localparam int AER_ADDR_W    = $clog2(AER_N_NEURONS);
    localparam int AER_TS_W      = 16;
    localparam int AER_DROP_W    = 16;

    typedef struct packed {
        logic [AER_ADDR_W-1:0] addr;
        logic [AER_TS_W-1:0]   ts;
    } aer_word_t;

    function automatic int next_index(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/spike_aer_encoder_rr_arbiter.sv
// Rotating-priority arbiter: first set request at or above ptr, wrapping to 0.
module rr_arbiter
    import spike_aer_pkg::*;
#(
    parameter int N     = AER_N_NEURONS,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int               j;
    logic [IDX_W-1:0] jj;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        jj  = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            jj = IDX_W'(j);
            if (!any && req[jj]) begin
                any     = 1'b1;
                gnt[jj] = 1'b1;
                idx     = jj;
            end
        end
    end

endmodule

// File: rtl/spike_aer_encoder.sv
// Collects per-neuron spike pulses and serialises them as round-robin AER words.
// Optional timestamping is enabled by defining AER_TIMESTAMP_EN.
module spike_aer_encoder
    import spike_aer_pkg::*;
#(
    parameter int N_NEURONS = AER_N_NEURONS,
    parameter int ADDR_W    = $clog2(N_NEURONS),
    parameter int TS_W      = AER_TS_W,
    parameter int DROP_W    = AER_DROP_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_NEURONS-1:0] spike_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDR_W-1:0]    out_addr,
    output logic [TS_W-1:0]      out_ts,
    output logic                 pending,
    output logic [DROP_W-1:0]    drop_cnt
);

    localparam int CNT_W = $clog2(N_NEURONS + 1);
    localparam int SUM_W = DROP_W + CNT_W;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    logic [N_NEURONS-1:0] pend;
    logic [N_NEURONS-1:0] gnt;
    logic [N_NEURONS-1:0] clr;
    logic [N_NEURONS-1:0] drop_vec;
    logic [ADDR_W-1:0]    rr_ptr;
    logic [ADDR_W-1:0]    gnt_idx;
    logic                 gnt_any;
    logic                 slot_free;
    logic                 grant_en;
    logic [CNT_W-1:0]     n_drop;
    logic [SUM_W-1:0]     drop_sum;
    logic [DROP_W-1:0]    drop_nxt;

    rr_arbiter #(
        .N     (N_NEURONS),
        .IDX_W (ADDR_W)
    ) u_arb (
        .req (pend),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    assign slot_free = !out_valid || out_ready;
    assign grant_en  = slot_free && gnt_any;
    assign clr       = grant_en ? gnt : '0;
    // A re-fire on the neuron being granted this cycle is a fresh event, not a drop.
    assign drop_vec  = spike_in & pend & ~clr;
    assign pending   = |pend;

    always_comb begin
        n_drop = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            n_drop = n_drop + CNT_W'(drop_vec[i]);
        end
        drop_sum = SUM_W'(drop_cnt) + SUM_W'(n_drop);
        drop_nxt = (drop_sum > SUM_W'(DROP_MAX)) ? DROP_MAX : drop_sum[DROP_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend      <= '0;
            rr_ptr    <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            drop_cnt  <= '0;
        end else begin
            pend     <= (pend & ~clr) | spike_in;
            drop_cnt <= drop_nxt;
            if (grant_en) begin
                out_valid <= 1'b1;
                out_addr  <= gnt_idx;
                rr_ptr    <= ADDR_W'(next_index(int'(gnt_idx), N_NEURONS));
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef AER_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_cnt <= '0;
            out_ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
            if (grant_en) out_ts <= ts_cnt;
        end
    end
`else
    assign out_ts = '0;
`endif

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Directed bench for spike_aer_encoder with a per-cycle behavioural reference model.
module tb_spike_aer_encoder;

    localparam int N    = 16;
    localparam int AW   = 4;
    localparam int TW   = 4;
    localparam int DW   = 4;
    localparam int DMAX = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  spike_in = '0;
    logic          out_ready = 1'b1;
    logic          out_valid;
    logic [AW-1:0] out_addr;
    logic [TW-1:0] out_ts;
    logic          pending;
    logic [DW-1:0] drop_cnt;

    always #5 clk = ~clk;

    spike_aer_encoder #(
        .N_NEURONS (N),
        .ADDR_W    (AW),
        .TS_W      (TW),
        .DROP_W    (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .spike_in  (spike_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_ts    (out_ts),
        .pending   (pending),
        .drop_cnt  (drop_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending set, rotating pointer, one held output word.
    bit m_pend[N];
    int m_ptr = 0, m_addr = 0, m_ts = 0, m_tsc = 0, m_drop = 0;
    bit m_valid = 1'b0;
    int acc_addr[$];
    int acc_ts[$];

    task automatic model_step();
        int g;
        bit free;
        if (rst) begin
            for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
            m_ptr = 0; m_valid = 1'b0; m_addr = 0; m_ts = 0; m_tsc = 0; m_drop = 0;
            return;
        end
        free = !m_valid || out_ready;
        g = -1;
        if (free) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        if (m_valid && out_ready) begin
            acc_addr.push_back(m_addr);
            acc_ts.push_back(m_ts);
        end
        for (int i = 0; i < N; i++) begin
            if (spike_in[i] && m_pend[i] && i != g) m_drop = (m_drop >= DMAX) ? DMAX : m_drop + 1;
        end
        if (g >= 0) begin
            m_pend[g] = 1'b0;
            m_valid   = 1'b1;
            m_addr    = g;
            m_ts      = m_tsc;
            m_ptr     = (g + 1) % N;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (spike_in[i]) m_pend[i] = 1'b1;
        end
        m_tsc = (m_tsc + 1) % (1 << TW);
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        bit any_p;
        if (chk_en) begin
            any_p = 1'b0;
            for (int i = 0; i < N; i++) any_p |= m_pend[i];
            check("out_valid", 32'(out_valid), 32'(m_valid));
            check("out_addr", 32'(out_addr), 32'(m_addr));
`ifdef AER_TIMESTAMP_EN
            check("out_ts", 32'(out_ts), 32'(m_ts));
`else
            check("out_ts", 32'(out_ts), 32'd0);
`endif
            check("pending", 32'(pending), 32'(any_p));
            check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        spike_in = '0;
        out_ready = 1'b1;
        cyc(1);
        rst = 1'b0;
        acc_addr.delete();
        acc_ts.delete();
    endtask

    initial begin
        cyc(3);
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_addr", 32'(out_addr), 32'd0);
        check("rst_ts", 32'(out_ts), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);

        // single spike: two-cycle latency, one beat
        cyc(6);
        spike_in = 16'h0001;
        cyc(1);
        spike_in = '0;
        check("single_lat1_valid", 32'(out_valid), 32'd0);
        check("single_lat1_pend", 32'(pending), 32'd1);
        cyc(1);
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_addr", 32'(out_addr), 32'd0);
        check("single_pend", 32'(pending), 32'd0);
        cyc(1);
        check("single_done", 32'(out_valid), 32'd0);
        cyc(3);
        check("single_beats", 32'(acc_addr.size()), 32'd1);

        // all neurons at once
        do_reset();
        spike_in = 16'hFFFF;
        cyc(1);
        spike_in = '0;
        cyc(20);
        check("burst_beats", 32'(acc_addr.size()), 32'd16);
        for (int i = 0; i < 16 && i < acc_addr.size(); i++) begin
            check("burst_addr", 32'(acc_addr[i]), 32'(i));
`ifdef AER_TIMESTAMP_EN
            check("burst_ts", 32'(acc_ts[i]), 32'((acc_ts[0] + i) % 16));
`endif
        end
        check("burst_drop", 32'(drop_cnt), 32'd0);
        check("burst_pend", 32'(pending), 32'd0);

        // fairness: 3 and 5 fire continuously for six cycles
        do_reset();
        spike_in = 16'h0028;
        cyc(6);
        spike_in = '0;
        cyc(6);
        check("fair_beats", 32'(acc_addr.size()), 32'd7);
        for (int i = 0; i < 7 && i < acc_addr.size(); i++) begin
            check("fair_addr", 32'(acc_addr[i]), (i % 2 == 0) ? 32'd3 : 32'd5);
        end
        check("fair_drop", 32'(drop_cnt), 32'd5);

        // stall on neuron 7
        do_reset();
        out_ready = 1'b0;
        spike_in = 16'h0080;
        cyc(1);
        spike_in = '0;
        cyc(20);
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_addr", 32'(out_addr), 32'd7);
        spike_in = 16'h0080;
        cyc(1);
        spike_in = '0;
        check("stall_refire_drop", 32'(drop_cnt), 32'd0);
        check("stall_refire_pend", 32'(pending), 32'd1);
        spike_in = 16'h0080;
        cyc(1);
        spike_in = '0;
        check("stall_refire2_drop", 32'(drop_cnt), 32'd1);
        out_ready = 1'b1;
        cyc(5);
        check("stall_beats", 32'(acc_addr.size()), 32'd2);
        for (int i = 0; i < 2 && i < acc_addr.size(); i++) begin
            check("stall_beat_addr", 32'(acc_addr[i]), 32'd7);
        end
        check("stall_end_valid", 32'(out_valid), 32'd0);

        // drop counter saturation, then reset mid-burst
        do_reset();
        out_ready = 1'b0;
        spike_in = 16'h0001;
        cyc(1);
        spike_in = 16'hFFFF;
        cyc(1);
        check("sat_nodrop", 32'(drop_cnt), 32'd0);
        cyc(2);
        spike_in = '0;
        check("sat_drop", 32'(drop_cnt), 32'd15);
        cyc(2);
        check("sat_hold", 32'(drop_cnt), 32'd15);
        out_ready = 1'b1;
        cyc(2);
        check("mid_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_pend", 32'(pending), 32'd0);
        check("mrst_drop", 32'(drop_cnt), 32'd0);
        check("mrst_addr", 32'(out_addr), 32'd0);
        acc_addr.delete();
        acc_ts.delete();
        cyc(5);
        check("mrst_quiet", 32'(out_valid), 32'd0);
        check("mrst_beats", 32'(acc_addr.size()), 32'd0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
